// File: rtl/ps2_pkg.sv
// PS/2 shared definitions: FSM states, frame bit indices, command codes.
// Used by both the host transmitter and the receive path.
package ps2_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_REQ       = 3'd2;
  localparam logic [2:0] ST_SEND      = 3'd3;
  localparam logic [2:0] ST_ACK       = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

  localparam logic [3:0] PS2_BIT_PARITY = 4'd8;
  localparam logic [3:0] PS2_BIT_STOP   = 4'd9;

  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
  localparam logic [7:0] PS2_RESP_ACK   = 8'hFA;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 pad conditioner: 2-flop synchroniser plus a stability filter.
// The level only moves after FILTER_LEN consecutive disagreeing samples.
module ps2_line_filter #(
  parameter int FILTER_LEN = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic pad,
  output logic level,
  output logic fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // bring the asynchronous pad into the clock domain
  always_ff @(posedge clock) begin
    if (reset) sync <= 2'b11;
    else       sync <= {sync[0], pad};
  end

  // debounce; fall pulses in the cycle the level first reads 0
  always_ff @(posedge clock) begin
    if (reset) begin
      level <= 1'b1;
      cnt   <= '0;
      fall  <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync[1];
        cnt   <= '0;
        fall  <= level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11 bits,
// device ACK check, then wait for the bus to go idle.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int SETUP_CYCLES   = 50,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       io_cmd_valid,
  output logic       io_cmd_ready,
  input  logic [7:0] io_cmd_bits,
  input  logic       io_kclk_in,
  input  logic       io_kdata_in,
  output logic       io_kclk_oe,
  output logic       io_kdata_oe,
  output logic       io_busy,
  output logic       io_done,
  output logic       io_err
);

  localparam int DLY_MAX = (INHIBIT_CYCLES > SETUP_CYCLES)
                         ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int DW = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [DW-1:0] INH_LAST = DW'(INHIBIT_CYCLES - 1);
  localparam logic [DW-1:0] SET_LAST = DW'(SETUP_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]    state;
  logic [7:0]    shreg;
  logic          par;
  logic [3:0]    bitcnt;
  logic          dbit_oe;
  logic          err_r;
  logic [DW-1:0] dly_cnt;
  logic [TW-1:0] to_cnt;

  logic kclk_lvl;
  logic kclk_fall;
  logic kdata_lvl;
  logic unused_kdata_fall;
  logic idle_seen;
  logic to_hit;
  logic nbit;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_kclk (
    .clock (clock),
    .reset (reset),
    .pad   (io_kclk_in),
    .level (kclk_lvl),
    .fall  (kclk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_kdata (
    .clock (clock),
    .reset (reset),
    .pad   (io_kdata_in),
    .level (kdata_lvl),
    .fall  (unused_kdata_fall)
  );

  assign idle_seen = kclk_lvl & kdata_lvl;
  assign to_hit    = (to_cnt == TO_LAST);

  assign io_cmd_ready = (state == ST_IDLE);
  assign io_busy      = (state != ST_IDLE);
  assign io_kclk_oe   = (state == ST_INHIBIT) || (state == ST_REQ);
  assign io_kdata_oe  = (state == ST_REQ) ||
                        ((state == ST_SEND) && dbit_oe);
  assign io_done      = (state == ST_WAIT_IDLE) && (idle_seen || to_hit);
  assign io_err       = io_done && (err_r || !idle_seen);

  // frame bit to present after the current kclk fall
  always_comb begin
    nbit = 1'b1;
    unique case (1'b1)
      (bitcnt < PS2_BIT_PARITY):  nbit = shreg[bitcnt[2:0]];
      (bitcnt == PS2_BIT_PARITY): nbit = par;
      default:                    nbit = 1'b1;
    endcase
  end

  // transfer sequencer with per-edge timeout
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      par     <= 1'b0;
      bitcnt  <= '0;
      dbit_oe <= 1'b0;
      err_r   <= 1'b0;
      dly_cnt <= '0;
      to_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (io_cmd_valid) begin
            shreg   <= io_cmd_bits;
            par     <= odd_parity(io_cmd_bits);
            err_r   <= 1'b0;
            dly_cnt <= '0;
            state   <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          if (dly_cnt == INH_LAST) begin
            dly_cnt <= '0;
            state   <= ST_REQ;
          end else begin
            dly_cnt <= dly_cnt + 1'b1;
          end
        end
        ST_REQ: begin
          if (dly_cnt == SET_LAST) begin
            dly_cnt <= '0;
            bitcnt  <= '0;
            dbit_oe <= 1'b1;
            to_cnt  <= '0;
            state   <= ST_SEND;
          end else begin
            dly_cnt <= dly_cnt + 1'b1;
          end
        end
        ST_SEND: begin
          if (kclk_fall) begin
            to_cnt  <= '0;
            dbit_oe <= ~nbit;
            bitcnt  <= bitcnt + 1'b1;
            if (bitcnt == PS2_BIT_STOP) state <= ST_ACK;
          end else if (to_hit) begin
            err_r   <= 1'b1;
            dbit_oe <= 1'b0;
            to_cnt  <= '0;
            state   <= ST_WAIT_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_ACK: begin
          if (kclk_fall) begin
            err_r  <= kdata_lvl;
            to_cnt <= '0;
            state  <= ST_WAIT_IDLE;
          end else if (to_hit) begin
            err_r  <= 1'b1;
            to_cnt <= '0;
            state  <= ST_WAIT_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_WAIT_IDLE: begin
          if (idle_seen || to_hit) begin
            to_cnt <= '0;
            state  <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a clocking device model.
// Scaled-down timing parameters keep the run short.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH = 60;
  localparam int SET = 10;
  localparam int TO  = 1500;
  localparam int FL  = 4;
  localparam int H   = 30;

  logic       clock;
  logic       reset;
  logic       io_cmd_valid;
  logic       io_cmd_ready;
  logic [7:0] io_cmd_bits;
  logic       io_kclk_oe;
  logic       io_kdata_oe;
  logic       io_busy;
  logic       io_done;
  logic       io_err;
  logic       dev_clk;
  logic       dev_data;
  logic       kclk_line;
  logic       kdata_line;

  assign kclk_line  = dev_clk & ~io_kclk_oe;
  assign kdata_line = dev_data & ~io_kdata_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .SETUP_CYCLES   (SET),
    .TIMEOUT_CYCLES (TO),
    .FILTER_LEN     (FL)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .io_cmd_valid (io_cmd_valid),
    .io_cmd_ready (io_cmd_ready),
    .io_cmd_bits  (io_cmd_bits),
    .io_kclk_in   (kclk_line),
    .io_kdata_in  (kdata_line),
    .io_kclk_oe   (io_kclk_oe),
    .io_kdata_oe  (io_kdata_oe),
    .io_busy      (io_busy),
    .io_done      (io_done),
    .io_err       (io_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  logic       done_seen;
  logic       done_err;
  logic       done_oe;
  logic       done_rdy;
  logic       scramble;
  logic [7:0] next_bits;

  function automatic logic [10:0] frame(input logic [7:0] b);
    logic p;
    p = ($countones(b) % 2 == 0);
    return {1'b1, p, b, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    if (io_done) begin
      done_seen = 1'b1;
      done_err  = io_err;
      done_oe   = io_kclk_oe | io_kdata_oe;
      done_rdy  = io_cmd_ready;
      if (scramble) begin
        scramble    = 1'b0;
        io_cmd_bits = next_bits;
      end
    end else if (scramble) begin
      io_cmd_bits = 8'($urandom);
    end
  endtask

  task automatic send_cmd(input logic [7:0] b, input logic hold);
    for (int i = 0; i < 20 && !io_cmd_ready; i++) tick();
    check("ready_before_cmd", io_cmd_ready, 1);
    done_seen    = 1'b0;
    io_cmd_bits  = b;
    io_cmd_valid = 1'b1;
    tick();
    if (!hold) io_cmd_valid = 1'b0;
  endtask

  task automatic wait_release(output int inh, output int rq);
    inh = 0;
    rq  = 0;
    for (int i = 0; i < INH + SET + 100; i++) begin
      if (!io_kclk_oe) return;
      if (io_kdata_oe) rq++;
      else inh++;
      tick();
    end
  endtask

  task automatic dev_xfer(input logic ack, input int nfall,
                          output logic [10:0] seen);
    seen = '1;
    for (int i = 0; i < 11; i++) begin
      if (i == nfall) return;
      if (i == 10 && ack) dev_data = 1'b0;
      repeat (H) tick();
      if (i == 0) seen[0] = kdata_line;
      dev_clk = 1'b0;
      repeat (H) tick();
      if (i < 10) seen[i+1] = kdata_line;
      dev_clk = 1'b1;
    end
    repeat (H) tick();
    dev_data = 1'b1;
  endtask

  task automatic wait_done();
    for (int i = 0; i < TO + 200 && !done_seen; i++) tick();
    check("done_seen", done_seen, 1);
  endtask

  task automatic full_xfer(input logic [7:0] b, input logic ack);
    int inh;
    int rq;
    logic [10:0] seen;
    send_cmd(b, 1'b0);
    wait_release(inh, rq);
    check("inhibit_cycles", inh, INH);
    check("setup_cycles", rq, SET);
    dev_xfer(ack, 11, seen);
    check("line_frame", seen, frame(b));
    wait_done();
    check("done_err", done_err, !ack);
    check("done_oe", done_oe, 0);
    check("done_not_ready", done_rdy, 0);
  endtask

  initial begin
    int inh;
    int rq;
    logic [10:0] seen;
    logic [7:0] a;
    logic [7:0] b;

    reset        = 1'b1;
    io_cmd_valid = 1'b0;
    io_cmd_bits  = '0;
    dev_clk      = 1'b1;
    dev_data     = 1'b1;
    done_seen    = 1'b0;
    done_err     = 1'b0;
    done_oe      = 1'b0;
    done_rdy     = 1'b0;
    scramble     = 1'b0;
    next_bits    = '0;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_ready", io_cmd_ready, 1);
    check("rst_busy", io_busy, 0);
    check("rst_oe", {io_kclk_oe, io_kdata_oe}, 0);
    check("rst_done", {io_done, io_err}, 0);

    // enable reporting, acknowledged
    full_xfer(PS2_CMD_ENABLE, 1'b1);

    // all-zero byte: parity bit is 1; ready the cycle after done
    full_xfer(8'h00, 1'b1);
    tick();
    check("ready_after_done", io_cmd_ready, 1);

    // reset command, device withholds ACK
    full_xfer(PS2_CMD_RESET, 1'b0);

    // device never clocks: timeout
    send_cmd(8'h5A, 1'b0);
    wait_release(inh, rq);
    check("to_release", inh + rq, INH + SET);
    wait_done();
    check("to_err", done_err, 1);
    check("to_oe", done_oe, 0);
    tick();
    check("to_busy", io_busy, 0);

    // reset mid-frame after four data bits
    send_cmd(PS2_CMD_ENABLE, 1'b0);
    wait_release(inh, rq);
    dev_xfer(1'b1, 4, seen);
    check("pre_rst_busy", io_busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_oe", {io_kclk_oe, io_kdata_oe}, 0);
    check("mid_rst_ready", io_cmd_ready, 1);
    check("mid_rst_done", io_done, 0);
    repeat (10) tick();
    full_xfer(PS2_CMD_ENABLE, 1'b1);

    // valid held with churning bits: only first byte, then next
    a = 8'($urandom);
    b = 8'($urandom);
    next_bits = b;
    send_cmd(a, 1'b1);
    scramble = 1'b1;
    wait_release(inh, rq);
    check("hold_release", inh + rq, INH + SET);
    dev_xfer(1'b1, 11, seen);
    check("hold_frame_a", seen, frame(a));
    wait_done();
    check("hold_err_a", done_err, 0);
    check("hold_not_ready", done_rdy, 0);
    tick();
    check("hold_ready", io_cmd_ready, 1);
    tick();
    check("hold_busy_b", io_busy, 1);
    io_cmd_valid = 1'b0;
    done_seen = 1'b0;
    wait_release(inh, rq);
    check("hold_release_b", inh + rq, INH + SET);
    dev_xfer(1'b1, 11, seen);
    check("hold_frame_b", seen, frame(b));
    wait_done();
    check("hold_err_b", done_err, 0);

    // random bytes with random ACK behaviour
    for (int k = 0; k < 4; k++) begin
      full_xfer(8'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
